// File: rtl/rr_encode_pkg.sv
// Shared definitions for the round-robin encoder.
//   state_e   : two-state output register encoding; out_valid is the state bit.
//   req_count : request count N = 1 << LEN, for sizing the request vectors.
package rr_encode_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int unsigned req_count(input int unsigned len);
    return 32'd1 << len;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set picker, purely combinational.
// Starting at position ptr and wrapping modulo N, it finds the first set bit
// of req and returns its index.
//   req  [N-1:0]   in  : request vector
//   ptr  [LEN-1:0] in  : highest-priority position
//   pick [LEN-1:0] out : index of the first set request in search order
//   any            out : at least one request is set
module rr_pick
  import rr_encode_pkg::*;
#(
  parameter  int LEN = 2,
  localparam int N   = int'(req_count(LEN))
) (
  input  logic [N-1:0]   req,
  input  logic [LEN-1:0] ptr,
  output logic [LEN-1:0] pick,
  output logic           any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] window;
  logic [2*N-1:0] masked;
  logic [LEN:0]   first;

  // Doubling the vector turns the wrap-around search into a plain linear
  // search. The window keeps positions ptr .. ptr+N-1 of the doubled vector,
  // so the lowest set bit of the masked vector is the round-robin winner.
  // Its index modulo N is simply its low LEN bits.
  always_comb begin
    // NOTE: every variable gets a default first so that no path through this
    // block leaves it unassigned, which would infer a latch.
    req_dbl = {req, req};
    window  = {{N{1'b0}}, {N{1'b1}}} << ptr;
    masked  = req_dbl & window;
    first   = '0;
    // Descending scan: the last hit written is the lowest set position.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) first = (LEN+1)'(j);
    end
    pick = first[LEN-1:0];
    any  = |req;
  end

endmodule

// File: rtl/rr_encode.sv
// Registered round-robin encoder.
// Selects one asserted request (rotating priority) and presents its binary
// index on a valid/ready output that is held stable under backpressure.
//   clk                   in  : rising-edge clock
//   rst_n                 in  : synchronous active-low reset
//   en                    in  : allows new selections
//   req       [N-1:0]     in  : request vector
//   out_ready             in  : consumer accepts the current output
//   out_valid             out : out_idx / grant are valid
//   out_idx   [LEN-1:0]   out : index of the selected requester
//   grant     [N-1:0]     out : one-hot of out_idx while valid, else zero
//   req_ack   [N-1:0]     out : grant qualified by the handshake (combinational)
module rr_encode
  import rr_encode_pkg::*;
#(
  parameter  int LEN = 2,
  localparam int N   = int'(req_count(LEN))
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [LEN-1:0] out_idx,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   req_ack
);

  state_e         state_q, state_d;
  logic [LEN-1:0] ptr_q, ptr_d;
  logic [LEN-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]   grant_q, grant_d;

  logic [LEN-1:0] pick;
  logic           pick_any;
  logic           load;

  rr_pick #(.LEN(LEN)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    // A new pick is taken only when the output register is free or being
    // drained this cycle; while FULL and stalled, load is forced low.
    load      = en & pick_any & ((state_q == ST_EMPTY) | out_ready);

    state_d   = state_q;
    ptr_d     = ptr_q;
    out_idx_d = out_idx_q;
    grant_d   = grant_q;

    if (load) begin
      ptr_d = pick + LEN'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d   = ST_FULL;
          out_idx_d = pick;
          grant_d   = {{(N-1){1'b0}}, 1'b1} << pick;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (load) begin
            out_idx_d = pick;
            grant_d   = {{(N-1){1'b0}}, 1'b1} << pick;
          end else begin
            // out_idx deliberately keeps its last value when draining.
            state_d = ST_EMPTY;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; reset is synchronous, checked first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      out_idx_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_idx_q <= out_idx_d;
      grant_q   <= grant_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_idx   = out_idx_q;
  assign grant     = grant_q;
  assign req_ack   = grant_q & {N{out_valid & out_ready}};

endmodule
